// File: rtl/gt_frame_pkg.sv
// gt_frame_pkg: shared FSM state encoding, K-character constants and PRBS-31 definition
package gt_frame_pkg;
  typedef enum logic [2:0] {S_IDLE, S_ALIGN, S_SOP, S_PAYLOAD, S_CC} state_t;
  localparam logic [7:0] K_SOP   = 8'hFB;
  localparam logic [7:0] K_COMMA = 8'hBC;
  localparam logic [7:0] K_CC    = 8'h1C;
  // x^31 + x^28 + 1: feedback from the bits generated 31 and 28 steps earlier
  localparam int PRBS_TAP_A = 30;
  localparam int PRBS_TAP_B = 27;
  localparam logic [30:0] PRBS_SEED = 31'h7FFFFFFF;
endpackage

// File: rtl/gt_prbs_par.sv
// gt_prbs_par: parallel PRBS-31 generator, WIDTH bits per advance
//   clk, rst_n (sync, active-low) | advance: step state by WIDTH bits
//   reseed: load PRBS_SEED (wins over advance) | word: current word, bit 0 generated first
module gt_prbs_par
  import gt_frame_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             advance,
  input  logic             reseed,
  output logic [WIDTH-1:0] word
);
  logic [30:0] state, state_nxt;
  always_comb begin
    state_nxt = state;
    word = '0;
    for (int i = 0; i < WIDTH; i++) begin
      state_nxt = {state_nxt[29:0], state_nxt[PRBS_TAP_A] ^ state_nxt[PRBS_TAP_B]};
      word[i] = state_nxt[0];
    end
  end
  always_ff @(posedge clk)
    if (!rst_n || reseed) state <= PRBS_SEED;
    else if (advance) state <= state_nxt;
endmodule

// File: rtl/gt_frame_gen_prbs.sv
// gt_frame_gen_prbs: GT TX frame generator (comma align, SOP + PRBS-31 frames, CC bursts)
//   USER_CLK, SYSTEM_RESET_N (sync, active-low), TX_RESETDONE_IN (low forces realign)
//   INJECT_ERR_IN: one-shot bit-0 error request, active only with GT_FRAME_GEN_ERR_INJECT_EN
//   TX_DATA_OUT / TXCHARISK_OUT: registered word and per-byte K flags
//   TX_FRAME_START_OUT, TX_CC_OUT, ERR_INJECTED_OUT: pulses aligned with their word
//   FRAME_COUNT_OUT: completed frames, cleared only by reset
module gt_frame_gen_prbs
  import gt_frame_pkg::*;
#(
  parameter int TX_DATA_WIDTH  = 32,
  parameter int TXCTRL_WIDTH   = TX_DATA_WIDTH / 8,
  parameter int WORDS_IN_FRAME = 512,
  parameter int ALIGN_WORDS    = 64,
  parameter int CC_INTERVAL    = 5000,
  parameter int CC_LEN         = 2,
  parameter logic [7:0] START_OF_PACKET_CHAR = K_SOP,
  parameter logic [7:0] COMMA_CHAR           = K_COMMA,
  parameter logic [7:0] CC_CHAR              = K_CC
) (
  input  logic                     USER_CLK,
  input  logic                     SYSTEM_RESET_N,
  input  logic                     TX_RESETDONE_IN,
  input  logic                     INJECT_ERR_IN,
  output logic [TX_DATA_WIDTH-1:0] TX_DATA_OUT,
  output logic [TXCTRL_WIDTH-1:0]  TXCHARISK_OUT,
  output logic                     TX_FRAME_START_OUT,
  output logic                     TX_CC_OUT,
  output logic [15:0]              FRAME_COUNT_OUT,
  output logic                     ERR_INJECTED_OUT
);
  localparam int NB = TX_DATA_WIDTH / 8;
  localparam int AW = $clog2(ALIGN_WORDS + 1);
  localparam int WW = $clog2(WORDS_IN_FRAME);
  localparam int CW = $clog2(CC_INTERVAL + 1);
  localparam int LW = $clog2(CC_LEN + 1);

  state_t state, state_nxt, ret_state, ret_nxt;
  logic [AW-1:0] align_cnt, align_nxt;
  logic [WW-1:0] idx, idx_nxt;
  logic [CW-1:0] cc_cnt, cc_cnt_nxt;
  logic [LW-1:0] cc_len_cnt, cc_len_nxt;
  logic [15:0] frame_nxt;
  logic [TX_DATA_WIDTH-1:0] data_nxt, prbs_word;
  logic [TXCTRL_WIDTH-1:0] k_nxt;
  logic sop_nxt, cc_nxt, err_nxt, advance, reseed, flip;
  logic last_align, last_pay, cc_due, last_cc;

  gt_prbs_par #(.WIDTH(TX_DATA_WIDTH)) u_prbs (
    .clk    (USER_CLK),
    .rst_n  (SYSTEM_RESET_N),
    .advance(advance),
    .reseed (reseed),
    .word   (prbs_word)
  );

  assign last_align = align_cnt == AW'(ALIGN_WORDS - 1);
  assign last_pay   = idx == WW'(WORDS_IN_FRAME - 2);
  assign cc_due     = cc_cnt == CW'(CC_INTERVAL - 1);
  assign last_cc    = cc_len_cnt == LW'(CC_LEN - 1);

`ifdef GT_FRAME_GEN_ERR_INJECT_EN
  logic inj_q, armed;
  assign flip = armed && state == S_PAYLOAD && TX_RESETDONE_IN;
  always_ff @(posedge USER_CLK)
    if (!SYSTEM_RESET_N) begin
      inj_q <= 1'b0;
      armed <= 1'b0;
    end else begin
      inj_q <= INJECT_ERR_IN;
      armed <= TX_RESETDONE_IN && (armed ? !flip : INJECT_ERR_IN && !inj_q);
    end
`else
  logic unused_inj;
  assign unused_inj = INJECT_ERR_IN;
  assign flip = 1'b0;
`endif

  // PRBS sits at the seed outside a frame and is reseeded on the last payload word,
  // so a CC burst between frames leaves the seed in place for the next SOP.
  always_comb begin
    state_nxt  = state;
    ret_nxt    = ret_state;
    align_nxt  = '0;
    idx_nxt    = idx;
    cc_cnt_nxt = '0;
    cc_len_nxt = '0;
    frame_nxt  = FRAME_COUNT_OUT;
    data_nxt   = '0;
    k_nxt      = '0;
    sop_nxt    = 1'b0;
    cc_nxt     = 1'b0;
    err_nxt    = flip;
    advance    = 1'b0;
    reseed     = 1'b1;
    case (state)
      S_IDLE: if (TX_RESETDONE_IN) state_nxt = S_ALIGN;
      S_ALIGN: begin
        data_nxt  = {NB{COMMA_CHAR}};
        k_nxt     = '1;
        align_nxt = last_align ? '0 : align_cnt + 1'b1;
        if (last_align) state_nxt = S_SOP;
      end
      S_SOP: begin
        data_nxt   = {prbs_word[TX_DATA_WIDTH-1:8], START_OF_PACKET_CHAR};
        k_nxt      = TXCTRL_WIDTH'(1);
        sop_nxt    = 1'b1;
        idx_nxt    = '0;
        ret_nxt    = S_PAYLOAD;
        cc_cnt_nxt = cc_due ? '0 : cc_cnt + 1'b1;
        state_nxt  = cc_due ? S_CC : S_PAYLOAD;
      end
      S_PAYLOAD: begin
        data_nxt   = prbs_word ^ TX_DATA_WIDTH'(flip);
        advance    = !last_pay;
        reseed     = last_pay;
        idx_nxt    = last_pay ? '0 : idx + 1'b1;
        frame_nxt  = last_pay ? FRAME_COUNT_OUT + 16'd1 : FRAME_COUNT_OUT;
        if (last_pay) ret_nxt = S_SOP;
        else ret_nxt = S_PAYLOAD;
        cc_cnt_nxt = cc_due ? '0 : cc_cnt + 1'b1;
        state_nxt  = cc_due ? S_CC : ret_nxt;
      end
      S_CC: begin
        data_nxt   = {NB{CC_CHAR}};
        k_nxt      = '1;
        cc_nxt     = 1'b1;
        reseed     = 1'b0;
        cc_len_nxt = last_cc ? '0 : cc_len_cnt + 1'b1;
        if (last_cc) state_nxt = ret_state;
      end
      default: state_nxt = S_IDLE;
    endcase
    // Link loss: abandon the frame without counting it, restart from alignment.
    if (!TX_RESETDONE_IN) begin
      state_nxt  = S_IDLE;
      align_nxt  = '0;
      idx_nxt    = '0;
      cc_cnt_nxt = '0;
      cc_len_nxt = '0;
      frame_nxt  = FRAME_COUNT_OUT;
      data_nxt   = '0;
      k_nxt      = '0;
      sop_nxt    = 1'b0;
      cc_nxt     = 1'b0;
      err_nxt    = 1'b0;
      advance    = 1'b0;
      reseed     = 1'b1;
    end
  end

  always_ff @(posedge USER_CLK)
    if (!SYSTEM_RESET_N) begin
      state              <= S_IDLE;
      ret_state          <= S_SOP;
      align_cnt          <= '0;
      idx                <= '0;
      cc_cnt             <= '0;
      cc_len_cnt         <= '0;
      FRAME_COUNT_OUT    <= '0;
      TX_DATA_OUT        <= '0;
      TXCHARISK_OUT      <= '0;
      TX_FRAME_START_OUT <= 1'b0;
      TX_CC_OUT          <= 1'b0;
      ERR_INJECTED_OUT   <= 1'b0;
    end else begin
      state              <= state_nxt;
      ret_state          <= ret_nxt;
      align_cnt          <= align_nxt;
      idx                <= idx_nxt;
      cc_cnt             <= cc_cnt_nxt;
      cc_len_cnt         <= cc_len_nxt;
      FRAME_COUNT_OUT    <= frame_nxt;
      TX_DATA_OUT        <= data_nxt;
      TXCHARISK_OUT      <= k_nxt;
      TX_FRAME_START_OUT <= sop_nxt;
      TX_CC_OUT          <= cc_nxt;
      ERR_INJECTED_OUT   <= err_nxt;
    end
endmodule

// File: tb/tb_gt_frame_gen_prbs.sv
// tb_gt_frame_gen_prbs: scoreboard bench for gt_frame_gen_prbs (short frames, frequent CC)
module tb_gt_frame_gen_prbs;
  localparam int W = 32, KW = 4, WIF = 8, AL = 64, CCI = 20, CCL = 2;
`ifdef GT_FRAME_GEN_ERR_INJECT_EN
  localparam bit INJ = 1'b1;
`else
  localparam bit INJ = 1'b0;
`endif

  typedef struct packed {
    logic [31:0] d;
    logic [3:0]  k;
    logic        sop;
    logic        cc;
    logic [15:0] fc;
    logic        err;
  } item_t;

  logic clk = 1'b0, rst_n = 1'b0, rdy = 1'b1, inj = 1'b0;
  logic [W-1:0] data;
  logic [KW-1:0] k;
  logic sop, cc, err;
  logic [15:0] fc;
  item_t obs, exp_i;
  item_t q[$];
  logic [31:0] gold [WIF-1];
  logic [15:0] fc_model = 16'd0;
  int tests = 0, fails = 0;

  always #5 clk = ~clk;
  assign obs = {data, k, sop, cc, fc, err};

  gt_frame_gen_prbs #(
    .TX_DATA_WIDTH(W), .TXCTRL_WIDTH(KW), .WORDS_IN_FRAME(WIF),
    .ALIGN_WORDS(AL), .CC_INTERVAL(CCI), .CC_LEN(CCL)
  ) dut (
    .USER_CLK(clk), .SYSTEM_RESET_N(rst_n), .TX_RESETDONE_IN(rdy), .INJECT_ERR_IN(inj),
    .TX_DATA_OUT(data), .TXCHARISK_OUT(k), .TX_FRAME_START_OUT(sop), .TX_CC_OUT(cc),
    .FRAME_COUNT_OUT(fc), .ERR_INJECTED_OUT(err)
  );

  // Golden PRBS-31 as a bit recurrence b[n] = b[n-31] ^ b[n-28], history all ones.
  task automatic build_gold();
    logic [31+32*(WIF-1)-1:0] seq;
    for (int i = 0; i < 31; i++) seq[i] = 1'b1;
    for (int i = 31; i < 31 + 32 * (WIF - 1); i++) seq[i] = seq[i-31] ^ seq[i-28];
    for (int j = 0; j < WIF - 1; j++)
      for (int b = 0; b < 32; b++) gold[j][b] = seq[31 + 32*j + b];
  endtask

  // Expected stream after (re)alignment: commas, then frames with a CC burst every CCI data words.
  task automatic push_stream(input int n_data, input logic [15:0] fc0, input bit flip);
    item_t it;
    logic [15:0] f;
    int c, p;
    f = fc0;
    c = 0;
    for (int i = 0; i < AL; i++) q.push_back('{d:32'hBCBCBCBC, k:4'hF, sop:1'b0, cc:1'b0, fc:f, err:1'b0});
    for (int n = 0; n < n_data; n++) begin
      p = n % WIF;
      if (p == 0) it = '{d:{gold[0][31:8], 8'hFB}, k:4'h1, sop:1'b1, cc:1'b0, fc:f, err:1'b0};
      else begin
        if (p == WIF - 1) f = f + 16'd1;
        it = '{d:gold[p-1], k:4'h0, sop:1'b0, cc:1'b0, fc:f, err:1'b0};
        if (flip && n == 1) begin
          it.d[0] = ~it.d[0];
          it.err = 1'b1;
        end
      end
      q.push_back(it);
      c++;
      if (c == CCI) begin
        c = 0;
        repeat (CCL) q.push_back('{d:32'h1C1C1C1C, k:4'hF, sop:1'b0, cc:1'b1, fc:f, err:1'b0});
      end
    end
    fc_model = f;
  endtask

  task automatic wait_nonzero(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 10 && !ok; i++) begin
      @(posedge clk); #1;
      ok = (data != '0);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    tests++;
    if (obs !== '0) begin
      fails++;
      $display("FAIL reset_state: got %h expected 0", obs);
    end
    @(posedge clk); #1;
    tests++;
    if (obs !== '0) begin
      fails++;
      $display("FAIL reset_hold: got %h expected 0", obs);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_frames_cc();
    bit ok;
    push_stream(40, 16'd0, 1'b0);
    wait_nonzero(ok);
    if (!ok) begin
      tests++; fails++;
      $display("FAIL frames_sync: got no output expected comma within 10 cycles");
      q.delete();
    end
    while (q.size() > 0) begin
      exp_i = q.pop_front();
      tests++;
      if (obs !== exp_i) begin
        fails++;
        $display("FAIL frames_word: got %h expected %h", obs, exp_i);
      end
      if (q.size() > 0) begin @(posedge clk); #1; end
    end
  endtask

  task automatic test_resetdone_drop();
    bit ok;
    repeat (3) begin @(posedge clk); #1; end
    tests++;
    if (data !== gold[1] || k !== 4'h0) begin
      fails++;
      $display("FAIL drop_pre_payload: got %h/%h expected %h/0", data, k, gold[1]);
    end
    rdy = 1'b0;
    @(posedge clk); #1;
    rdy = 1'b1;
    tests++;
    if (obs !== item_t'({32'h0, 4'h0, 1'b0, 1'b0, fc_model, 1'b0})) begin
      fails++;
      $display("FAIL drop_zero: got %h expected fc %h rest 0", obs, fc_model);
    end
    push_stream(16, fc_model, 1'b0);
    wait_nonzero(ok);
    if (!ok) begin
      tests++; fails++;
      $display("FAIL drop_sync: got no output expected comma within 10 cycles");
      q.delete();
    end
    while (q.size() > 0) begin
      exp_i = q.pop_front();
      tests++;
      if (obs !== exp_i) begin
        fails++;
        $display("FAIL drop_word: got %h expected %h", obs, exp_i);
      end
      if (q.size() > 0) begin @(posedge clk); #1; end
    end
  endtask

  task automatic test_reset_in_cc();
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 60 && !seen; i++) begin
      @(posedge clk); #1;
      seen = cc;
    end
    tests++;
    if (!seen) begin
      fails++;
      $display("FAIL cc_wait: got no CC word expected one within 60 cycles");
    end
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    tests++;
    if (obs !== '0) begin
      fails++;
      $display("FAIL reset_in_cc: got %h expected 0", obs);
    end
  endtask

  task automatic test_err_inject();
    bit ok;
    int i;
    i = 0;
    push_stream(16, 16'd0, INJ);
    wait_nonzero(ok);
    if (!ok) begin
      tests++; fails++;
      $display("FAIL inject_sync: got no output expected comma within 10 cycles");
      q.delete();
    end
    while (q.size() > 0) begin
      exp_i = q.pop_front();
      tests++;
      if (obs !== exp_i) begin
        fails++;
        $display("FAIL inject_word %0d: got %h expected %h", i, obs, exp_i);
      end
      inj = (i == 2 || i == 10);
      i++;
      if (q.size() > 0) begin @(posedge clk); #1; end
    end
    inj = 1'b0;
  endtask

  initial begin
    build_gold();
    test_reset();
    test_frames_cc();
    test_resetdone_drop();
    test_reset_in_cc();
    test_err_inject();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/gt_frame_gen_prbs.md
Name: gt_frame_gen_prbs

Overview:
- TX-side frame generator that drives the GT transmit datapath.
- Feeds the receive-side frame checker across the serial link: comma alignment preamble, then repeating frames of one SOP word plus PRBS-31 payload, with periodic clock-correction (CC) bursts.
- The checker's expected-data image is generated from the same PRBS-31 sequence and frame length, so frame N payload word k is identical on both sides.

Parameters:
- TX_DATA_WIDTH, 32, TX data width in bits; multiple of 8, range 16..64.
- TXCTRL_WIDTH, 4, K-char flag bits, one per byte (TX_DATA_WIDTH/8).
- WORDS_IN_FRAME, 512, words per frame including the SOP word; must be >= 2.
- ALIGN_WORDS, 64, comma words sent after reset or link-ready before the first frame.
- CC_INTERVAL, 5000, cycles between CC burst requests.
- CC_LEN, 2, words per CC burst.
- START_OF_PACKET_CHAR, 8'hFB, K-char in byte 0 of the SOP word.
- COMMA_CHAR, 8'hBC, K28.5 used for alignment words.
- CC_CHAR, 8'h1C, K28.0 used for CC words.

Ports:
- USER_CLK  in  1  TX user clock.
- SYSTEM_RESET_N  in  1  synchronous, active-low reset.
- TX_RESETDONE_IN  in  1  GT TX ready; low forces realignment.
- INJECT_ERR_IN  in  1  single-bit error request (optional feature).
- TX_DATA_OUT  out  TX_DATA_WIDTH  transmit data.
- TXCHARISK_OUT  out  TXCTRL_WIDTH  per-byte K flag.
- TX_FRAME_START_OUT  out  1  high coincident with the SOP word.
- TX_CC_OUT  out  1  high coincident with each CC word.
- FRAME_COUNT_OUT  out  16  completed frames, wraps at 16'hFFFF->0.
- ERR_INJECTED_OUT  out  1  one-cycle pulse coincident with the corrupted word.

Behaviour:
- One clock; reset is synchronous and active-low. SYSTEM_RESET_N sampled on the USER_CLK edge; no asynchronous path.
- All outputs registered. Output word reflects the state and counters of the previous cycle (1-cycle latency).
- Reset values:
  - TX_DATA_OUT=0, TXCHARISK_OUT=0, all pulses 0, FRAME_COUNT_OUT=0.
  - State S_IDLE, PRBS seed 31'h7FFFFFFF.
- States:
  - S_IDLE: output 0. Go to S_ALIGN when TX_RESETDONE_IN=1.
  - S_ALIGN: every byte COMMA_CHAR, all K bits 1. After ALIGN_WORDS words, go to S_SOP.
  - S_SOP: byte0=START_OF_PACKET_CHAR, TXCHARISK bit0=1. Upper bytes = first PRBS word's upper bytes, K=0; PRBS does not advance. TX_FRAME_START_OUT=1. Go to S_PAYLOAD.
  - S_PAYLOAD: PRBS words, K=0, PRBS advances once per word. After WORDS_IN_FRAME-1 payload words: FRAME_COUNT_OUT+1, go to S_SOP.
  - S_CC: CC_LEN words, every byte CC_CHAR, all K=1, TX_CC_OUT=1. Then resume the interrupted state at the same word index.
- PRBS-31 (x^31+x^28+1):
  - Parallel generation, TX_DATA_WIDTH bits per advance.
  - Bit 0 = earliest generated bit.
  - Reseeded to 31'h7FFFFFFF at every S_SOP, so every frame carries identical payload.
- CC scheduling:
  - CC counter held at 0 outside S_SOP/S_PAYLOAD.
  - Reaching CC_INTERVAL-1 sets cc_pending.
  - Pending burst starts after the current word completes; counter restarts at burst start.
  - Word index and PRBS frozen during S_CC. A CC never splits a word.
  - Pending at the last payload word: burst precedes the next SOP.
- TX_RESETDONE_IN low in any state:
  - Next cycle go to S_IDLE.
  - Clear cc_pending and the word index; PRBS reseeds.
  - FRAME_COUNT_OUT retained; only reset clears it.
- Reset mid-frame: immediate return to reset values; no partial-frame completion.

Optional Feature:
- Macro GT_FRAME_GEN_ERR_INJECT_EN.
- Defined:
  - Rising edge of INJECT_ERR_IN arms a one-shot.
  - The next S_PAYLOAD word has bit 0 inverted and ERR_INJECTED_OUT pulses with it.
  - Further requests while armed are ignored.
  - Arm cleared by reset or TX_RESETDONE_IN low.
  - PRBS state itself unaffected.
- Undefined: INJECT_ERR_IN ignored; ERR_INJECTED_OUT tied 0.

Decomposition:
- Package gt_frame_pkg:
  - state enum (S_IDLE, S_ALIGN, S_SOP, S_PAYLOAD, S_CC);
  - K-char constants;
  - PRBS-31 polynomial taps and seed.
- Sub-module gt_prbs_par: parallel PRBS generator with advance and reseed inputs, width parameter, combinational next-word output, registered state.

Test Plan:
- Reset release with TX_RESETDONE_IN=1 -> 64 words of 32'hBCBCBCBC/K=4'hF, then SOP word with byte0=8'hFB, K=4'h1, TX_FRAME_START_OUT=1.
- Full frame run (WORDS_IN_FRAME=8, CC disabled via large CC_INTERVAL) -> 7 payload words match golden PRBS-31; second frame payload identical; FRAME_COUNT_OUT=1 then 2.
- CC_INTERVAL=20, CC_LEN=2 -> two 32'h1C1C1C1C/K=4'hF words every 22 output words; payload sequence continuous across the bursts.
- TX_RESETDONE_IN low for 1 cycle mid-payload -> output zero next cycle, full 64-word realign, payload restarts at seed; FRAME_COUNT_OUT unchanged.
- SYSTEM_RESET_N low for one cycle during S_CC -> all outputs 0 and FRAME_COUNT_OUT=0 on the following cycle.
- With GT_FRAME_GEN_ERR_INJECT_EN, INJECT_ERR_IN pulse during S_ALIGN -> first payload word differs from golden only in bit 0, ERR_INJECTED_OUT=1 once; subsequent words correct.
